// File: rtl/sw2led2.sv
// Switch-to-LED path: 2-flop synchronizer, per-bit debounce counter, registered LEDs and change pulses.
// Latency 2 + max(DEBOUNCE_CYCLES,1) edges from a stable switch change; no backpressure (free-running).
module sw2led2 #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] ld,
  output logic [WIDTH-1:0] chg
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_ld;
  logic [WIDTH-1:0] r_chg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ld  <= '0;
          r_chg <= '0;
        end else begin
          r_ld  <= r_sync2;
          r_chg <= r_sync2 ^ r_ld;
        end
      end
    end else begin : g_debounce
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] r_cnt [WIDTH];

      // Counter i holds how many consecutive edges sync2[i] has disagreed with ld[i].
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
          r_ld  <= '0;
          r_chg <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            r_chg[i] <= 1'b0;
            if (r_sync2[i] == r_ld[i]) begin
              r_cnt[i] <= '0;
            end else if (r_cnt[i] == LAST) begin
              r_ld[i]  <= r_sync2[i];
              r_chg[i] <= 1'b1;
              r_cnt[i] <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + CW'(1);
            end
          end
        end
      end
    end
  endgenerate

  assign ld  = r_ld;
  assign chg = r_chg;

endmodule

// File: tb/tb_sw2led2.sv
// Randomized self-checking bench for sw2led2 (default debounce and bypass instances) against a history-window model.
module tb_sw2led2;

  localparam int W  = 8;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw;
  logic [W-1:0] ld, chg, ld0, chg0;

  int checks = 0;
  int errors = 0;

  sw2led2 #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .sw(sw), .ld(ld), .chg(chg)
  );

  sw2led2 #(.WIDTH(W), .DEBOUNCE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .sw(ld0_sw_dummy()), .ld(ld0), .chg(chg0)
  );

  function automatic logic [W-1:0] ld0_sw_dummy();
    return sw;
  endfunction

  always #5 clk = ~clk;

  // Reference: sw values captured at past edges, and the synchronized value seen at each edge.
  logic [W-1:0] swq [$];
  logic [W-1:0] s2q [$];
  logic [W-1:0] m_ld, m_chg, m_ld0, m_chg0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    swq.delete();
    s2q.delete();
    m_ld = '0; m_chg = '0; m_ld0 = '0; m_chg0 = '0;
  endtask

  // Bit i flips once the last DC synchronized samples all disagree with the current LED.
  task automatic model_edge();
    logic [W-1:0] s2, nxt;
    bit flip;
    if (rst) begin
      model_clear();
      return;
    end
    s2 = (swq.size() >= 2) ? swq[swq.size()-2] : '0;
    s2q.push_back(s2);
    nxt = m_ld;
    for (int i = 0; i < W; i++) begin
      flip = (s2q.size() >= DC);
      if (flip)
        for (int k = 0; k < DC; k++)
          if (s2q[s2q.size()-1-k][i] == m_ld[i]) flip = 0;
      if (flip) nxt[i] = ~m_ld[i];
    end
    m_chg  = nxt ^ m_ld;
    m_ld   = nxt;
    m_chg0 = s2 ^ m_ld0;
    m_ld0  = s2;
    swq.push_back(sw);
    while (swq.size() > 8) void'(swq.pop_front());
    while (s2q.size() > 8) void'(s2q.pop_front());
  endtask

  task automatic step(input logic [W-1:0] v);
    sw = v;
    @(posedge clk);
    model_edge();
    #1;
    chk("ld",   32'(ld),   32'(m_ld));
    chk("chg",  32'(chg),  32'(m_chg));
    chk("ld0",  32'(ld0),  32'(m_ld0));
    chk("chg0", 32'(chg0), 32'(m_chg0));
  endtask

  task automatic async_reset_now();
    rst = 1'b1;
    model_clear();
    #1;
    chk("arst_ld",  32'(ld),   32'h0);
    chk("arst_chg", 32'(chg),  32'h0);
    chk("arst_ld0", 32'(ld0),  32'h0);
  endtask

  initial begin
    rst = 1'b1;
    sw  = 8'hFF;
    model_clear();

    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_ld",   32'(ld),   32'h0);
      chk("rst_chg",  32'(chg),  32'h0);
      chk("rst_ld0",  32'(ld0),  32'h0);
      chk("rst_chg0", 32'(chg0), 32'h0);
    end
    sw  = 8'h00;
    rst = 1'b0;
    repeat (8) step(8'h00);

    for (int e = 1; e <= 7; e++) begin
      step(8'h95);
      if (e == 5) chk("lat95_early", 32'(ld), 32'h00);
      if (e == 6) chk("lat95_ld",    32'(ld), 32'h95);
      if (e == 6) chk("lat95_chg",   32'(chg), 32'h95);
      if (e == 7) chk("lat95_chg_end", 32'(chg), 32'h00);
      if (e == 3) chk("byp95_ld",    32'(ld0), 32'h95);
    end

    for (int e = 1; e <= 7; e++) begin
      step(8'hFB);
      if (e == 6) begin
        chk("fb_ld",     32'(ld), 32'hFB);
        chk("fb_signed", 32'($signed(ld)), 32'(-5));
        chk("fb_chg",    32'(chg), 32'h6E);
      end
    end

    repeat (8) step(8'h00);
    repeat (3) step(8'h01);
    repeat (8) begin
      step(8'h00);
      chk("glitch_ld",  32'(ld),  32'h00);
      chk("glitch_chg", 32'(chg), 32'h00);
    end

    repeat (4) step(8'h3C);
    #2;
    async_reset_now();
    repeat (2) step(8'h3C);
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step(8'h3C);
      if (e == 5) chk("rel_early", 32'(ld), 32'h00);
      if (e == 6) chk("rel_ld",    32'(ld), 32'h3C);
    end

    repeat (8) step(8'h00);
    for (int e = 1; e <= 4; e++) begin
      step(8'hA5);
      if (e == 2) chk("byp_early", 32'(ld0),  32'h00);
      if (e == 3) chk("byp_ld",    32'(ld0),  32'hA5);
      if (e == 3) chk("byp_chg",   32'(chg0), 32'hA5);
      if (e == 4) chk("byp_chg_end", 32'(chg0), 32'h00);
    end

    for (int n = 0; n < 150; n++) begin
      logic [W-1:0] v;
      int sel;
      v   = W'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 6) begin
        repeat ($urandom_range(1, 8)) step(v);
      end else if (sel < 9) begin
        logic [W-1:0] base;
        base = sw;
        repeat ($urandom_range(1, 5)) step(base ^ (W'(1) << $urandom_range(0, W-1)));
        repeat ($urandom_range(1, 3)) step(base);
      end else begin
        #($urandom_range(1, 3));
        async_reset_now();
        repeat ($urandom_range(1, 2)) step(v);
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
